apb_master_bridge: RTL and testbench

//  APB requester (initiator) that turns single commands from a valid/ready command port

---
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into APB SETUP/ACCESS transfers.
// Latency: accept@0 -> psel@1 -> penable@2 -> rsp_valid@(3 + wait states); 1 cmd per 4 cycles min.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready, stalling new commands.
//
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata   command port (valid/ready)
//   rsp_valid/ready/rdata/err    response port (valid/ready)
//   psel/penable/pwrite/paddr/pwdata   APB request outputs (all registered)
//   prdata/pready/pslverr        APB completion inputs (sampled only in ACCESS)
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // Counter must hold values up to TIMEOUT-1; keep at least one bit when TIMEOUT=0.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic                psel_q,      psel_d;
  logic                penable_q,   penable_d;
  logic                pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,     paddr_d;
  logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = SETUP;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          paddr_d    = cmd_addr;
          pwrite_d   = cmd_write;
          // Reads drive zero on pwdata so stale write data never leaks onto the bus.
          pwdata_d   = cmd_write ? cmd_wdata : '0;
          wait_cnt_d = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          // This was the TIMEOUT-th ACCESS cycle without pready: abandon the transfer.
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized transfers.
// The reference model derives, per transfer, the expected bus phase timing and
// response purely from command, wait-state count, slave error and timeout rules.
module tb_apb_master_bridge;

  localparam int TMO = 4;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int vec_cnt = 0;
  int err_cnt = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Random values on slave inputs; the bridge must ignore them outside ACCESS.
  task automatic slave_noise();
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
  endtask

  // Random command-port activity while the bridge is busy; must be ignored.
  task automatic cmd_noise();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  // One complete transfer. Called and returns at a negedge with the bridge idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int waits, input logic slverr,
                      input int rdly);
    logic [31:0] exp_wd, exp_rd;
    logic        exp_err;
    bit          abort;
    int          acc;
    exp_wd  = wr ? wdata : 32'h0;
    abort   = (TMO != 0) && (waits >= TMO);
    acc     = abort ? TMO : waits + 1;            // ACCESS cycles
    exp_err = abort ? 1'b1 : slverr;
    exp_rd  = (abort || wr) ? 32'h0 : rdata;

    chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 1'($urandom);
    slave_noise();
    @(negedge pclk);                               // cycle 1

    for (int n = 1; n <= acc + 1; n++) begin
      chk("psel",      {31'h0, psel},      32'h1);
      chk("penable",   {31'h0, penable},   (n >= 2) ? 32'h1 : 32'h0);
      chk("paddr",     paddr,              addr);
      chk("pwrite",    {31'h0, pwrite},    {31'h0, wr});
      chk("pwdata",    pwdata,             exp_wd);
      chk("rsp_valid_busy", {31'h0, rsp_valid}, 32'h0);
      chk("cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
      cmd_noise();
      rsp_ready = 1'($urandom);
      if (n >= 2) begin
        pready = ((n - 2) >= waits);
        if (pready) begin
          pslverr = slverr;
          prdata  = rdata;
        end else begin
          pslverr = 1'($urandom);
          prdata  = $urandom;
        end
      end else begin
        slave_noise();
      end
      @(negedge pclk);
    end

    for (int k = 0; k <= rdly; k++) begin
      chk("rsp_valid",  {31'h0, rsp_valid}, 32'h1);
      chk("rsp_rdata",  rsp_rdata,          exp_rd);
      chk("rsp_err",    {31'h0, rsp_err},   {31'h0, exp_err});
      chk("psel_resp",  {31'h0, psel},      32'h0);
      chk("penable_resp", {31'h0, penable}, 32'h0);
      chk("cmd_ready_resp", {31'h0, cmd_ready}, 32'h0);
      chk("paddr_hold", paddr,              addr);
      chk("pwrite_hold", {31'h0, pwrite},   {31'h0, wr});
      chk("pwdata_hold", pwdata,            exp_wd);
      cmd_noise();
      slave_noise();
      rsp_ready = (k == rdly);
      @(negedge pclk);
    end

    chk("rsp_valid_done", {31'h0, rsp_valid}, 32'h0);
    chk("cmd_ready_done", {31'h0, cmd_ready}, 32'h1);
    chk("psel_done",      {31'h0, psel},      32'h0);
    cmd_valid = 1'b0;
    rsp_ready = 1'($urandom);
  endtask

  initial begin
    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);

    // Reset state
    chk("rst_psel",      {31'h0, psel},      32'h0);
    chk("rst_penable",   {31'h0, penable},   32'h0);
    chk("rst_pwrite",    {31'h0, pwrite},    32'h0);
    chk("rst_paddr",     paddr,              32'h0);
    chk("rst_pwdata",    pwdata,             32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata,          32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
    preset = 1'b0;
    @(negedge pclk);

    // Directed scenarios
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0, 0);          // zero-wait write
    xfer(1'b0, 32'h05, 32'h12345678, 32'h00000005, 0, 1'b0, 0);   // zero-wait read
    xfer(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 3, 1'b0, 1);          // 3 wait states
    xfer(1'b1, 32'h30, 32'h0BADF00D, 32'h0, 0, 1'b1, 0);          // slave error
    xfer(1'b0, 32'h34, 32'h0, 32'hA5A5A5A5, 0, 1'b0, 0);          // accepted after error
    xfer(1'b0, 32'h40, 32'h0, 32'h11111111, TMO + 3, 1'b0, 0);    // timeout abort (read)
    xfer(1'b1, 32'h44, 32'h22222222, 32'h0, TMO - 1, 1'b1, 0);    // longest non-abort wait
    xfer(1'b1, 32'h48, 32'h33333333, 32'h0, 2, 1'b0, 5);          // rsp_ready held low

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hABC0; cmd_wdata = 32'h55AA55AA;
    pready = 1'b0;
    @(negedge pclk);                               // SETUP
    cmd_valid = 1'b0;
    @(negedge pclk);                               // ACCESS
    chk("pre_rst_penable", {31'h0, penable}, 32'h1);
    preset = 1'b1;
    @(negedge pclk);
    chk("mid_rst_psel",      {31'h0, psel},      32'h0);
    chk("mid_rst_penable",   {31'h0, penable},   32'h0);
    chk("mid_rst_pwrite",    {31'h0, pwrite},    32'h0);
    chk("mid_rst_paddr",     paddr,              32'h0);
    chk("mid_rst_pwdata",    pwdata,             32'h0);
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    preset = 1'b0;
    @(negedge pclk);
    chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    xfer(1'b0, 32'h50, 32'h0, 32'h87654321, 1, 1'b0, 0);

    // Randomized transfers, with occasional idle gaps
    for (int t = 0; t < 60; t++) begin
      int gap;
      xfer(1'($urandom), $urandom, $urandom, $urandom,
           int'($urandom_range(0, TMO + 2)), 1'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 3)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        slave_noise();
        @(negedge pclk);
        chk("idle_psel", {31'h0, psel}, 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
